// File: rtl/dspi_ctrl_master.sv
// DSPI host-side control master: merges host commands into the forward packet
// stream at packet boundaries and tracks read responses with a timeout.
module dspi_ctrl_master #(
  parameter int DATA_WIDTH                  = 512,
  parameter int STREAM_ID_NUM               = 16,
  parameter int CHUNK_ID_NUM                = 32,
  parameter int CHANNEL_ID_NUM              = 1024,
  parameter int STATE_WIDTH                 = 32,
  parameter int CP_R_CTRL_READ_REQUEST_32b  = 0,
  parameter int CP_R_CTRL_WRITE_32b         = 1,
  parameter int CP_A_CTRL_READ_RESPONSE_32b = 1,
  parameter int TIMEOUT_CYCLES              = 1024,
  localparam int STREAM_ID_WIDTH  = $clog2(STREAM_ID_NUM),
  localparam int CHUNK_ID_WIDTH   = $clog2(CHUNK_ID_NUM),
  localparam int CHANNEL_ID_WIDTH = $clog2(CHANNEL_ID_NUM)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       S_Data,
  input  logic [1:0]                  S_Type,
  input  logic                        S_Last,
  input  logic [STREAM_ID_WIDTH-1:0]  S_StreamID,
  input  logic [CHUNK_ID_WIDTH-1:0]   S_ChunkID,
  input  logic [CHANNEL_ID_WIDTH-1:0] S_ChannelID,
  input  logic [STATE_WIDTH-1:0]      S_State,
  input  logic                        S_Valid,
  output logic                        S_Ready,
  input  logic                        Cmd_Valid,
  output logic                        Cmd_Ready,
  input  logic                        Cmd_Write,
  input  logic [CHANNEL_ID_WIDTH-1:0] Cmd_Hop,
  input  logic [STATE_WIDTH-1:0]      Cmd_Addr,
  input  logic [31:0]                 Cmd_WData,
  input  logic [1:0]                  Ret_Type,
  input  logic [CHUNK_ID_WIDTH-1:0]   Ret_ChunkID,
  input  logic [31:0]                 Ret_Data,
  output logic                        Rsp_Valid,
  output logic [31:0]                 Rsp_RData,
  output logic                        Rsp_Timeout,
  output logic [DATA_WIDTH-1:0]       M_Data,
  output logic [1:0]                  M_Type,
  output logic                        M_Last,
  output logic [STREAM_ID_WIDTH-1:0]  M_StreamID,
  output logic [CHUNK_ID_WIDTH-1:0]   M_ChunkID,
  output logic [CHANNEL_ID_WIDTH-1:0] M_ChannelID,
  output logic [STATE_WIDTH-1:0]      M_State
);

  localparam int OPW   = CHUNK_ID_WIDTH - 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [OPW-1:0]   OP_RD        = OPW'(CP_R_CTRL_READ_REQUEST_32b);
  localparam logic [OPW-1:0]   OP_WR        = OPW'(CP_R_CTRL_WRITE_32b);
  localparam logic [OPW-1:0]   OP_RSP       = OPW'(CP_A_CTRL_READ_RESPONSE_32b);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT_RSP} state_e;

  state_e                      state_q, state_d;
  logic                        in_pkt_q, in_pkt_d;
  logic                        cmd_turn_q, cmd_turn_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]       m_data_q, m_data_d;
  logic [1:0]                  m_type_q, m_type_d;
  logic                        m_last_q, m_last_d;
  logic [STREAM_ID_WIDTH-1:0]  m_stream_q, m_stream_d;
  logic [CHUNK_ID_WIDTH-1:0]   m_chunk_q, m_chunk_d;
  logic [CHANNEL_ID_WIDTH-1:0] m_channel_q, m_channel_d;
  logic [STATE_WIDTH-1:0]      m_state_q, m_state_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [31:0]                 rsp_rdata_q, rsp_rdata_d;
  logic                        rsp_timeout_q, rsp_timeout_d;

  logic inject;
  logic accept;
  logic rsp_match;
  logic unused_ret_type0;

  assign unused_ret_type0 = Ret_Type[0];

  // Commands only enter between packets; cmd_turn gives data one packet after each command.
  always_comb begin
    inject    = (state_q == IDLE) && Cmd_Valid && !in_pkt_q && (!S_Valid || cmd_turn_q);
    accept    = S_Valid && !inject;
    rsp_match = Ret_Type[1] && !Ret_ChunkID[CHUNK_ID_WIDTH-1] &&
                (Ret_ChunkID[OPW-1:0] == OP_RSP);
  end

  assign Cmd_Ready = inject;
  assign S_Ready   = !inject;

  always_comb begin
    state_d       = state_q;
    in_pkt_d      = in_pkt_q;
    cmd_turn_d    = cmd_turn_q;
    cnt_d         = cnt_q;
    m_data_d      = m_data_q;
    m_type_d      = 2'b00;
    m_last_d      = m_last_q;
    m_stream_d    = m_stream_q;
    m_chunk_d     = m_chunk_q;
    m_channel_d   = m_channel_q;
    m_state_d     = m_state_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = 1'b0;

    // A response arriving on the timeout cycle still counts as a match.
    if (state_q == WAIT_RSP) begin
      if (rsp_match) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = Ret_Data;
        state_d     = IDLE;
      end else if (cnt_q == TIMEOUT_LAST) begin
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = 32'hFFFF_FFFF;
        rsp_timeout_d = 1'b1;
        state_d       = IDLE;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (inject) begin
      m_type_d    = 2'b10;
      m_last_d    = 1'b1;
      m_stream_d  = '0;
      m_chunk_d   = {1'b1, (Cmd_Write ? OP_WR : OP_RD)};
      m_channel_d = Cmd_Hop;
      m_state_d   = Cmd_Addr;
      m_data_d    = Cmd_Write ? {(DATA_WIDTH/32){Cmd_WData}} : '0;
      cmd_turn_d  = 1'b0;
      if (Cmd_Write) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
      end else begin
        state_d = WAIT_RSP;
        cnt_d   = '0;
      end
    end else if (accept) begin
      m_data_d    = S_Data;
      m_type_d    = S_Type;
      m_last_d    = S_Last;
      m_stream_d  = S_StreamID;
      m_chunk_d   = S_ChunkID;
      m_channel_d = S_ChannelID;
      m_state_d   = S_State;
      if (S_Last) begin
        in_pkt_d   = 1'b0;
        cmd_turn_d = 1'b1;
      end else if (S_Type != 2'b00) begin
        in_pkt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      in_pkt_q      <= 1'b0;
      cmd_turn_q    <= 1'b1;
      cnt_q         <= '0;
      m_data_q      <= '0;
      m_type_q      <= '0;
      m_last_q      <= 1'b0;
      m_stream_q    <= '0;
      m_chunk_q     <= '0;
      m_channel_q   <= '0;
      m_state_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_pkt_q      <= in_pkt_d;
      cmd_turn_q    <= cmd_turn_d;
      cnt_q         <= cnt_d;
      m_data_q      <= m_data_d;
      m_type_q      <= m_type_d;
      m_last_q      <= m_last_d;
      m_stream_q    <= m_stream_d;
      m_chunk_q     <= m_chunk_d;
      m_channel_q   <= m_channel_d;
      m_state_q     <= m_state_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign M_Data      = m_data_q;
  assign M_Type      = m_type_q;
  assign M_Last      = m_last_q;
  assign M_StreamID  = m_stream_q;
  assign M_ChunkID   = m_chunk_q;
  assign M_ChannelID = m_channel_q;
  assign M_State     = m_state_q;
  assign Rsp_Valid   = rsp_valid_q;
  assign Rsp_RData   = rsp_rdata_q;
  assign Rsp_Timeout = rsp_timeout_q;

endmodule

// File: tb/tb_dspi_ctrl_master.sv
// Self-checking bench for dspi_ctrl_master: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_dspi_ctrl_master;

  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] s_data;
  logic [1:0]   s_type;
  logic         s_last;
  logic [3:0]   s_sid;
  logic [4:0]   s_cid;
  logic [9:0]   s_chid;
  logic [31:0]  s_state;
  logic         s_valid;
  logic         s_ready;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [9:0]   cmd_hop;
  logic [31:0]  cmd_addr, cmd_wdata;
  logic [1:0]   ret_type;
  logic [4:0]   ret_cid;
  logic [31:0]  ret_data;
  logic         rsp_valid, rsp_timeout;
  logic [31:0]  rsp_rdata;
  logic [511:0] m_data;
  logic [1:0]   m_type;
  logic         m_last;
  logic [3:0]   m_sid;
  logic [4:0]   m_cid;
  logic [9:0]   m_chid;
  logic [31:0]  m_state;

  dspi_ctrl_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .S_Data(s_data), .S_Type(s_type), .S_Last(s_last), .S_StreamID(s_sid),
    .S_ChunkID(s_cid), .S_ChannelID(s_chid), .S_State(s_state),
    .S_Valid(s_valid), .S_Ready(s_ready),
    .Cmd_Valid(cmd_valid), .Cmd_Ready(cmd_ready), .Cmd_Write(cmd_write),
    .Cmd_Hop(cmd_hop), .Cmd_Addr(cmd_addr), .Cmd_WData(cmd_wdata),
    .Ret_Type(ret_type), .Ret_ChunkID(ret_cid), .Ret_Data(ret_data),
    .Rsp_Valid(rsp_valid), .Rsp_RData(rsp_rdata), .Rsp_Timeout(rsp_timeout),
    .M_Data(m_data), .M_Type(m_type), .M_Last(m_last), .M_StreamID(m_sid),
    .M_ChunkID(m_cid), .M_ChannelID(m_chid), .M_State(m_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: which source owns the bus, whether a read is outstanding
  // and how long it has waited, plus the expected registered outputs.
  bit           m_busy, m_in_pkt, m_turn;
  int           m_waited;
  bit           took_cmd, took_data;
  logic [511:0] e_data;
  logic [1:0]   e_type;
  logic         e_last;
  logic [3:0]   e_sid;
  logic [4:0]   e_cid;
  logic [9:0]   e_chid;
  logic [31:0]  e_state;
  logic         e_rsp_valid, e_rsp_timeout;
  logic [31:0]  e_rsp_rdata;
  int           beats_left = 0;

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic modelReset();
    m_busy = 0; m_in_pkt = 0; m_turn = 1; m_waited = 0;
    e_data = '0; e_type = '0; e_last = 0; e_sid = '0; e_cid = '0; e_chid = '0; e_state = '0;
    e_rsp_valid = 0; e_rsp_timeout = 0; e_rsp_rdata = '0;
  endtask

  // One clock: inputs are already driven (just after a falling edge).
  task automatic applyStimulus();
    bit cmd_ok;
    #1;
    cmd_ok = !m_busy && cmd_valid && !m_in_pkt && (!s_valid || m_turn);
    checkOutput("cmd_ready", cmd_ready, cmd_ok);
    checkOutput("s_ready", s_ready, !cmd_ok);
    took_cmd = 0;
    took_data = 0;
    if (rst) begin
      modelReset();
    end else begin
      e_rsp_valid = 0;
      e_rsp_timeout = 0;
      if (m_busy) begin
        m_waited++;
        if (ret_type[1] && ret_cid == 5'b00001) begin
          e_rsp_valid = 1; e_rsp_rdata = ret_data; m_busy = 0;
        end else if (m_waited == TIMEOUT) begin
          e_rsp_valid = 1; e_rsp_timeout = 1; e_rsp_rdata = 32'hFFFF_FFFF; m_busy = 0;
        end
      end
      if (cmd_ok) begin
        took_cmd = 1;
        e_type = 2'b10; e_last = 1; e_sid = '0;
        e_cid = cmd_write ? 5'b10001 : 5'b10000;
        e_chid = cmd_hop; e_state = cmd_addr;
        e_data = cmd_write ? {16{cmd_wdata}} : '0;
        m_turn = 0;
        if (cmd_write) begin
          e_rsp_valid = 1; e_rsp_rdata = '0;
        end else begin
          m_busy = 1; m_waited = 0;
        end
      end else if (s_valid) begin
        took_data = 1;
        e_data = s_data; e_type = s_type; e_last = s_last; e_sid = s_sid;
        e_cid = s_cid; e_chid = s_chid; e_state = s_state;
        if (s_last) begin
          m_in_pkt = 0; m_turn = 1;
        end else if (s_type != 2'b00) begin
          m_in_pkt = 1;
        end
      end else begin
        e_type = 2'b00;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("m_type", m_type, e_type);
    checkOutput("m_meta", {m_last, m_sid, m_cid, m_chid, m_state},
                {e_last, e_sid, e_cid, e_chid, e_state});
    checkOutput("m_data", m_data, e_data);
    checkOutput("rsp_flags", {rsp_valid, rsp_timeout}, {e_rsp_valid, e_rsp_timeout});
    if (e_rsp_valid || rst) checkOutput("rsp_rdata", rsp_rdata, e_rsp_rdata);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    s_valid = 0; s_data = '0; s_type = '0; s_last = 0; s_sid = '0; s_cid = '0; s_chid = '0; s_state = '0;
    cmd_valid = 0; cmd_write = 0; cmd_hop = '0; cmd_addr = '0; cmd_wdata = '0;
    ret_type = '0; ret_cid = '0; ret_data = '0;
  endtask

  task automatic setBeat(input logic [1:0] typ, input logic last);
    for (int i = 0; i < 16; i++) s_data[i*32 +: 32] = $urandom();
    s_type = typ; s_last = last; s_sid = 4'($urandom());
    s_cid = 5'($urandom()); s_chid = 10'($urandom()); s_state = $urandom();
  endtask

  task automatic newBeat();
    if (beats_left == 0) begin
      beats_left = $urandom_range(1, 4);
      s_type = 2'($urandom_range(0, 3));
    end
    setBeat(s_type, beats_left == 1);
    beats_left--;
  endtask

  task automatic newCmd();
    cmd_write = 1'($urandom_range(0, 1));
    cmd_hop = 10'($urandom()); cmd_addr = $urandom(); cmd_wdata = $urandom();
  endtask

  task automatic doReset();
    rst = 1;
    idleInputs();
    applyStimulus();
    rst = 0;
  endtask

  logic [1:0] fair_types [8];
  int n_to;
  bit seen;

  initial begin
    rst = 1;
    idleInputs();
    modelReset();
    @(negedge clk);
    applyStimulus();
    checkOutput("reset_outputs", {m_data, m_type, m_last, m_sid, m_cid, m_chid, m_state,
                rsp_valid, rsp_rdata, rsp_timeout}, '0);
    rst = 0;

    // Write with no data traffic.
    cmd_valid = 1; cmd_write = 1; cmd_hop = 10'd3; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5_0001;
    applyStimulus();
    checkOutput("wr_chunk", m_cid, 5'b10001);
    checkOutput("wr_lanes", m_data, {16{32'hA5A5_0001}});
    checkOutput("wr_rsp", {rsp_valid, rsp_timeout}, 2'b10);
    cmd_valid = 0;
    applyStimulus();

    // Command arriving mid-packet waits for the Last beat.
    for (int b = 0; b < 4; b++) begin
      s_valid = 1;
      setBeat(2'b01, b == 3);
      if (b >= 1) begin cmd_valid = 1; cmd_write = 1; cmd_wdata = $urandom(); end
      applyStimulus();
      checkOutput("bnd_data_beat", m_type, 2'b01);
    end
    setBeat(2'b01, 1'b1);
    applyStimulus();
    checkOutput("bnd_ctrl_after_last", m_type, 2'b10);
    cmd_valid = 0;
    applyStimulus();
    s_valid = 0;

    // Read answered seven cycles after injection.
    cmd_valid = 1; cmd_write = 0; cmd_hop = '0; cmd_addr = 32'h4;
    applyStimulus();
    cmd_valid = 0;
    for (int i = 1; i < 7; i++) applyStimulus();
    ret_type = 2'b10; ret_cid = 5'b00001; ret_data = 32'h1234_5678;
    applyStimulus();
    checkOutput("rd_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {2'b10, 32'h1234_5678});
    ret_type = '0; ret_cid = '0;

    // Read with no answer times out; a late answer is ignored.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8;
    applyStimulus();
    cmd_valid = 0;
    n_to = 0; seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      applyStimulus();
      if (rsp_valid) begin seen = 1; n_to = i; end
    end
    checkOutput("to_latency", n_to, TIMEOUT);
    checkOutput("to_rsp", {rsp_timeout, rsp_rdata}, {1'b1, 32'hFFFF_FFFF});
    ret_type = 2'b10; ret_cid = 5'b00001; ret_data = 32'hDEAD_BEEF;
    applyStimulus();
    checkOutput("late_rsp_ignored", rsp_valid, 1'b0);
    ret_type = '0; ret_cid = '0;

    // Fairness with both sources continuously valid.
    doReset();
    cmd_valid = 1; newCmd(); cmd_write = 1;
    s_valid = 1; setBeat(2'b01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      fair_types[i] = m_type;
      if (took_cmd) begin newCmd(); cmd_write = 1; end
      if (took_data) setBeat(2'b01, 1'b1);
    end
    for (int i = 0; i < 8; i++)
      checkOutput("fair_alternate", fair_types[i], (i % 2 == 0) ? 2'b10 : 2'b01);
    idleInputs();

    // Reset while a read is outstanding.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
    applyStimulus();
    cmd_valid = 0;
    applyStimulus();
    applyStimulus();
    doReset();
    checkOutput("rst_wait_outputs", {m_type, rsp_valid, rsp_rdata}, '0);
    cmd_valid = 1; cmd_write = 1; cmd_wdata = 32'h5555_AAAA;
    s_valid = 1; setBeat(2'b01, 1'b1);
    applyStimulus();
    checkOutput("rst_cmd_first", m_type, 2'b10);
    cmd_valid = 0;
    s_valid = 0;
    for (int i = 0; i < 12; i++) applyStimulus();

    // Random traffic, occasional matching responses and resets.
    beats_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (took_data || !s_valid) begin
        s_valid = ($urandom_range(0, 9) < 7);
        if (s_valid) newBeat();
      end
      if (took_cmd || !cmd_valid) begin
        cmd_valid = ($urandom_range(0, 9) < 3);
        if (cmd_valid) newCmd();
      end
      if ($urandom_range(0, 9) < 2) begin
        ret_type = {1'b1, 1'($urandom())}; ret_cid = 5'b00001;
      end else begin
        ret_type = 2'($urandom()); ret_cid = 5'($urandom());
      end
      ret_data = $urandom();
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus();
      rst = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
